fpa_sched: RTL and testbench
============================

Name: fpa_sched

Overview:
- Shares one sequential fixed-point to IEEE-754 single-precision converter between N_REQ requesters.
- Each input word is sign-magnitude fixed point: 1 sign bit, INT_W integer bits, FRAC_W fraction bits.
- A round-robin arbiter grants one request at a time. A shift-based normaliser runs one bit per cycle. The result is returned on a valid/ready response port tagged with the requester index.
- Sits between the sample producers and the float datapath; replaces per-channel combinational converters.

Parameters:
- N_REQ, 4, number of requesters (power of two, >=2)
- INT_W, 8, integer bits of input magnitude
- FRAC_W, 5, fraction bits of input magnitude (INT_W+FRAC_W <= 24)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  N_REQ  per-requester request valid
- req_data  in  N_REQ*(1+INT_W+FRAC_W)  packed words; requester k occupies slice k; MSB of each word = sign
- req_ready  out  N_REQ  one-hot grant/accept (combinational, IDLE only)
- rsp_valid  out  1  result valid
- rsp_data  out  32  IEEE-754 single result
- rsp_id  out  clog2(N_REQ)  index of requester that owns rsp_data
- rsp_ready  in  1  consumer accepts result
- busy  out  1  high in NORM or DONE

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; rsp_valid=0, rsp_data=0, rsp_id=0.
  - RR pointer = N_REQ-1, so requester 0 has first priority.
  - Internal shift register and exponent cleared.
  - req_ready forced 0 while rst=1.
  - A reset in NORM or DONE discards the in-flight conversion; no response is produced.
- Notation: M = INT_W+FRAC_W magnitude width; E0 = 127+INT_W-1.
- IDLE:
  - If any req_valid is set, grant g = first valid index searching ptr+1, ptr+2, ... modulo N_REQ.
  - req_ready[g]=1 in that cycle only; the transfer occurs at that clk edge.
  - At that edge: capture sign, M-bit magnitude, id=g, exp=E0, ptr=g; go to NORM.
  - With no valid, stay in IDLE with req_ready=0.
- NORM, one cycle per step:
  - If magnitude==0: result=32'h00000000 (sign dropped, -0 maps to +0); go to DONE.
  - Else if magnitude[M-1]==1: result={sign, exp, bits magnitude[M-2:0] left-aligned in 23-bit mantissa, zero-filled}; go to DONE.
  - Else: shift magnitude left 1, exp=exp-1; stay in NORM.
  - At most M-1 shifts. Conversion is exact; no rounding, overflow or denormal cases exist for legal parameters.
- DONE:
  - rsp_valid=1; rsp_data and rsp_id are stable registers.
  - Hold until rsp_valid&&rsp_ready, then go to IDLE at that edge.
  - No new grant is issued in the handshake cycle.
- Latency: grant accepted in cycle T; rsp_valid first high in cycle T+2+lz, where lz = leading zeros of the M-bit magnitude. Zero input gives T+2.
- Throughput: one conversion per 3+lz cycles minimum with rsp_ready tied high.
- req_data of non-granted requesters is ignored. A requester must hold valid and data stable until it sees ready.
- Fairness: with all requesters continuously valid, grants cycle 0,1,...,N_REQ-1,0,...
- rsp_ready low in DONE: all outputs held unchanged indefinitely; req_ready stays 0.

Test Plan:
- Requester 0 sends 14'h0060 (+3.0; lz=6), grant at T -> rsp_data=32'h40400000, rsp_id=0, rsp_valid first at T+8.
- Requester 2 sends 14'h2030 (-1.5) -> 32'hBFC00000, rsp_id=2, valid at T+9. Then 14'h1FFF (255.96875) -> 32'h437FF800 at T+2. Then 14'h0001 (1/32) -> 32'h3D000000 at T+14.
- Zero cases: 14'h0000 and 14'h2000 each -> 32'h00000000 at T+2.
- All four requesters hold valid, rsp_ready=1 -> grant order 0,1,2,3,0,1; each req_ready pulse lasts exactly 1 cycle and is one-hot. Requesters 1 and 3 only -> grant order 1,3,1,3.
- rsp_ready held low 5 cycles in DONE -> rsp_valid, rsp_data and rsp_id are stable, busy=1, req_ready=0; the handshake on cycle 6 is followed by IDLE and a new grant on the next cycle.
- rst asserted during NORM of 14'h0001 -> next cycle all outputs 0, state IDLE, no response emitted. After release, pending requester 0 is granted first.

Source files
------------

// File: rtl/fpa_sched.sv
`default_nettype none
// ============================================================================
// Module   : fpa_sched
// Purpose  : Round-robin shared sign-magnitude fixed-point to IEEE-754 single
//            converter; shift normaliser steps one bit per cycle.
// Revision : 1.0  initial release
// ============================================================================
module fpa_sched #(
    parameter int N_REQ  = 4,
    parameter int INT_W  = 8,
    parameter int FRAC_W = 5
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [N_REQ-1:0]                      req_valid,
    input  logic [N_REQ*(1+INT_W+FRAC_W)-1:0]     req_data,
    output logic [N_REQ-1:0]                      req_ready,
    output logic                                  rsp_valid,
    output logic [31:0]                           rsp_data,
    output logic [$clog2(N_REQ)-1:0]              rsp_id,
    input  logic                                  rsp_ready,
    output logic                                  busy
);
    localparam int         c_ID_W = $clog2(N_REQ);
    localparam int         c_M    = INT_W + FRAC_W;
    localparam int         c_W    = c_M + 1;
    localparam logic [7:0] c_E0   = 8'(127 + INT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [c_ID_W-1:0]   r_ptr;
    logic [c_ID_W-1:0]   r_id;
    logic [c_ID_W-1:0]   w_gnt;
    logic [c_ID_W-1:0]   w_idx;
    logic                w_any;
    logic [c_M-1:0]      r_mag;
    logic                r_sign;
    logic [7:0]          r_exp;
    logic [31:0]         r_rsp_data;
    logic [c_W-1:0]      w_words [N_REQ];
    logic [c_W-1:0]      w_word;
    logic [22:0]         w_mant;

    for (genvar k = 0; k < N_REQ; k++) begin : g_unpack
        assign w_words[k] = req_data[k*c_W +: c_W];
    end

    // Search starts one past the last winner; the N_REQ-th step wraps to r_ptr.
    always_comb begin
        w_gnt = '0;
        w_any = 1'b0;
        w_idx = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            w_idx = r_ptr + c_ID_W'(i);
            if (!w_any && req_valid[w_idx]) begin
                w_gnt = w_idx;
                w_any = 1'b1;
            end
        end
    end

    assign w_word = w_words[w_gnt];

    always_comb begin
        req_ready = '0;
        if (!rst && (r_state == S_IDLE) && w_any) begin
            req_ready[w_gnt] = 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any) w_state_nxt = S_NORM;
            S_NORM:  if ((r_mag == '0) || r_mag[c_M-1]) w_state_nxt = S_DONE;
            S_DONE:  if (rsp_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The leading one is implicit; remaining bits sit left-aligned in the mantissa.
    always_comb begin
        w_mant = '0;
        w_mant[22 -: (c_M-1)] = r_mag[c_M-2:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr      <= c_ID_W'(N_REQ - 1);
            r_id       <= '0;
            r_mag      <= '0;
            r_sign     <= 1'b0;
            r_exp      <= '0;
            r_rsp_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_sign <= w_word[c_W-1];
                        r_mag  <= w_word[c_M-1:0];
                        r_id   <= w_gnt;
                        r_exp  <= c_E0;
                        r_ptr  <= w_gnt;
                    end
                end
                S_NORM: begin
                    if (r_mag == '0) begin
                        r_rsp_data <= '0;
                    end else if (r_mag[c_M-1]) begin
                        r_rsp_data <= {r_sign, r_exp, w_mant};
                    end else begin
                        r_mag <= r_mag << 1;
                        r_exp <= r_exp - 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign rsp_valid = (r_state == S_DONE);
    assign rsp_data  = r_rsp_data;
    assign rsp_id    = r_id;
    assign busy      = (r_state == S_NORM) || (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_fpa_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_fpa_sched
// Purpose  : Self-checking bench for fpa_sched; real-arithmetic float model
//            and round-robin grant model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fpa_sched;
    localparam int N_REQ  = 4;
    localparam int INT_W  = 8;
    localparam int FRAC_W = 5;
    localparam int M      = INT_W + FRAC_W;
    localparam int W      = M + 1;
    localparam int ID_W   = $clog2(N_REQ);

    logic                 clk;
    logic                 rst;
    logic [N_REQ-1:0]     req_valid;
    logic [N_REQ*W-1:0]   req_data;
    logic [N_REQ-1:0]     req_ready;
    logic                 rsp_valid;
    logic [31:0]          rsp_data;
    logic [ID_W-1:0]      rsp_id;
    logic                 rsp_ready;
    logic                 busy;

    int n_cmp = 0;
    int n_err = 0;
    int model_ptr = N_REQ - 1;

    fpa_sched #(.N_REQ(N_REQ), .INT_W(INT_W), .FRAC_W(FRAC_W)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Value = mag / 2^FRAC_W; the double's exponent and top mantissa bits are exact here.
    function automatic logic [31:0] ref_float(input logic [W-1:0] w);
        real         v;
        logic [63:0] d;
        int          e;
        if (w[M-1:0] == '0) return 32'h0;
        v = real'(w[M-1:0]) / real'(1 << FRAC_W);
        d = $realtobits(v);
        e = int'(d[62:52]) - 1023 + 127;
        return {w[W-1], 8'(e), d[51:29]};
    endfunction

    function automatic int ref_lat(input logic [W-1:0] w);
        logic [63:0] d;
        if (w[M-1:0] == '0) return 2;
        d = $realtobits(real'(w[M-1:0]));
        return 2 + (M - 1) - (int'(d[62:52]) - 1023);
    endfunction

    function automatic int rr_pick(input int ptr, input logic [N_REQ-1:0] v);
        for (int i = 1; i <= N_REQ; i++) begin
            if (v[(ptr + i) % N_REQ]) return (ptr + i) % N_REQ;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rand_word();
        logic [W-1:0] w;
        w = W'($urandom);
        if ($urandom_range(0, 9) == 0) w[M-1:0] = '0;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_ready_pre", 32'(req_ready), 32'd0);
        tick();
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_valid", 32'(rsp_valid), 32'd0);
        chk("rst_data", rsp_data, 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        model_ptr = N_REQ - 1;
    endtask

    task automatic grant_step(input int exp_id, output int g, output logic [W-1:0] w);
        int cyc;
        int mg;
        #1;
        cyc = 0;
        while (req_ready == '0 && cyc < 200) begin
            tick();
            cyc++;
        end
        chk("grant_seen", 32'(req_ready != '0), 32'd1);
        chk("grant_onehot", 32'($countones(req_ready)), 32'd1);
        g = 0;
        for (int i = 0; i < N_REQ; i++) if (req_ready[i]) g = i;
        mg = rr_pick(model_ptr, req_valid);
        chk("grant_rr", g, mg);
        if (exp_id >= 0) chk("grant_id", g, exp_id);
        w = req_data[g*W +: W];
        model_ptr = g;
    endtask

    task automatic serve(input int exp_id, input bit drop, output logic [31:0] o_data, output int o_lat);
        int           g;
        logic [W-1:0] w;
        grant_step(exp_id, g, w);
        tick();
        if (drop) req_valid[g] = 1'b0;
        else      req_data[g*W +: W] = rand_word();
        #1;
        chk("ready_pulse", 32'(req_ready), 32'd0);
        chk("busy_norm", 32'(busy), 32'd1);
        o_lat = 1;
        while (!rsp_valid && o_lat < 200) begin
            tick();
            o_lat++;
        end
        chk("latency", o_lat, ref_lat(w));
        chk("rsp_data", rsp_data, ref_float(w));
        chk("rsp_id", 32'(rsp_id), g);
        o_data = rsp_data;
        tick();
    endtask

    task automatic do_conv(input int id, input logic [W-1:0] word, input logic [31:0] exp_d, input int exp_l);
        logic [31:0] d;
        int          l;
        req_data[id*W +: W] = word;
        req_valid[id] = 1'b1;
        serve(id, 1'b1, d, l);
        chk("dir_data", d, exp_d);
        chk("dir_lat", l, exp_l);
    endtask

    initial begin
        logic [31:0]      d;
        int               l;
        int               g;
        int               cyc;
        logic [W-1:0]     w;
        logic [N_REQ-1:0] m;
        int               seq_all[6] = '{0, 1, 2, 3, 0, 1};
        int               seq_13[4]  = '{1, 3, 1, 3};

        rst = 1'b1;
        req_valid = '0;
        req_data = '0;
        rsp_ready = 1'b1;
        tick();
        do_reset();

        // Directed conversions with hand-derived results
        do_conv(0, 14'h0060, 32'h40400000, 8);
        do_conv(2, 14'h2030, 32'hBFC00000, 9);
        do_conv(2, 14'h1FFF, 32'h437FF800, 2);
        do_conv(2, 14'h0001, 32'h3D000000, 14);
        do_conv(1, 14'h0000, 32'h00000000, 2);
        do_conv(3, 14'h2000, 32'h00000000, 2);

        // Consumer stall in DONE with another requester waiting
        rsp_ready = 1'b0;
        req_data[1*W +: W] = 14'h0060;
        req_valid[1] = 1'b1;
        grant_step(1, g, w);
        tick();
        req_valid[1] = 1'b0;
        req_data[2*W +: W] = 14'h2030;
        req_valid[2] = 1'b1;
        #1;
        cyc = 0;
        while (!rsp_valid && cyc < 200) begin
            tick();
            cyc++;
        end
        for (int i = 1; i <= 5; i++) begin
            chk("stall_valid", 32'(rsp_valid), 32'd1);
            chk("stall_data", rsp_data, 32'h40400000);
            chk("stall_id", 32'(rsp_id), 32'd1);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_ready", 32'(req_ready), 32'd0);
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        chk("hs_valid", 32'(rsp_valid), 32'd1);
        chk("hs_ready", 32'(req_ready), 32'd0);
        tick();
        chk("post_hs_busy", 32'(busy), 32'd0);
        chk("post_hs_grant", 32'(req_ready), 32'h4);
        serve(2, 1'b1, d, l);
        chk("stall_next_data", d, 32'hBFC00000);
        chk("stall_next_lat", l, 9);

        // Reset during normalisation drops the conversion; pointer returns to N_REQ-1
        req_data[2*W +: W] = 14'h0001;
        req_valid[2] = 1'b1;
        grant_step(2, g, w);
        tick();
        req_valid[2] = 1'b0;
        tick();
        tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        req_data[0*W +: W] = 14'h0060;
        req_valid[0] = 1'b1;
        req_data[3*W +: W] = 14'h1FFF;
        req_valid[3] = 1'b1;
        do_reset();
        do_conv(0, 14'h0060, 32'h40400000, 8);
        do_conv(3, 14'h1FFF, 32'h437FF800, 2);

        // All requesters continuously valid
        do_reset();
        for (int k = 0; k < N_REQ; k++) req_data[k*W +: W] = rand_word();
        req_valid = '1;
        for (int i = 0; i < 6; i++) serve(seq_all[i], 1'b0, d, l);
        req_valid = '0;

        // Requesters 1 and 3 only
        do_reset();
        req_data[1*W +: W] = rand_word();
        req_data[3*W +: W] = rand_word();
        req_valid = 4'b1010;
        for (int i = 0; i < 4; i++) serve(seq_13[i], 1'b0, d, l);
        req_valid = '0;

        // Random request masks and words against the models
        for (int it = 0; it < 40; it++) begin
            m = N_REQ'($urandom_range(1, (1 << N_REQ) - 1));
            for (int k = 0; k < N_REQ; k++) begin
                if (m[k] && !req_valid[k]) begin
                    req_data[k*W +: W] = rand_word();
                    req_valid[k] = 1'b1;
                end
            end
            serve(-1, 1'b1, d, l);
        end
        req_valid = '0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
